ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Shares the single port of the 16K×8 system RAM between two requesters: CPU and DMA/loader.
- Sits between the Z80 bus glue, the loader engine and one port of the RAM.
- Arbitration is round-robin. Every access is a 3-cycle req/ack transaction.
- After reset, an optional clear sequencer fills the whole RAM with a constant before any requester is served.

Parameters:
- AW, 14, address width; RAM depth is 2^AW.
- DW, 8, data width.
- CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset release; 0 = go straight to IDLE.
- CLEAR_VALUE, 8'h00, byte written by the clear sweep.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, level; hold until cpu_ack.
- cpu_wr  in  1  active-low write enable (0 = write, 1 = read).
- cpu_a  in  AW  CPU address, stable while cpu_req.
- cpu_di  in  DW  CPU write data.
- cpu_do  out  DW  CPU read data, valid while cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req, dma_wr, dma_a, dma_di, dma_do, dma_ack: same as the cpu_* set, for the DMA requester.
- ram_wr  out  1  active-low RAM write strobe.
- ram_a  out  AW  RAM address.
- ram_di  out  DW  RAM write data.
- ram_do  in  DW  RAM registered read data; 1-cycle latency, write-first (a write returns the written data).
- busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset (asynchronous, reset=0):
  - ram_wr=1, ram_a=0, ram_di=0.
  - cpu_ack=dma_ack=0, cpu_do=dma_do=0.
  - Clear counter=0; priority pointer=CPU.
  - busy=CLEAR_ON_RESET; state=CLEAR if CLEAR_ON_RESET, else IDLE.
  - Reset asserted mid-sweep or mid-access aborts everything. The sweep restarts from address 0; an aborted transaction is never acked.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- CLEAR state, each edge:
  - ram_a<=cnt, ram_di<=CLEAR_VALUE, ram_wr<=0, cnt<=cnt+1.
  - On the edge where cnt==2^AW-1, go to CLR_END.
- CLR_END: ram_wr<=1, busy<=0, go to IDLE.
  - Sweep length: busy falls 2^AW+1 edges after reset release, and every address is written exactly once.
  - Requests raised during the sweep stay pending (req is level) and are served afterwards.
- IDLE, each edge:
  - If no req: ram_wr held 1, stay in IDLE.
  - Otherwise pick the winner:
    - only one req → that requester;
    - both → the one the priority pointer names (CPU after reset).
  - Register ram_a<=x_a, ram_di<=x_di, ram_wr<=x_wr; record the winner; go to ACCESS.
- ACCESS (edge E1):
  - The RAM performs the operation on this edge.
  - ram_wr<=1, so a write strobe lasts exactly one cycle; go to DONE.
- DONE (edge E2):
  - winner_do<=ram_do and winner_ack<=1 for one cycle; the loser's outputs are unchanged.
  - Flip the priority pointer to the non-winner; go to IDLE.
- Transaction timing:
  - Latency: req sampled at E0, ack high during the cycle after E2 (3 edges).
  - Maximum throughput: one access per 3 cycles.
- Handshake:
  - The requester must hold a, wr, di stable from req until ack.
  - req still high at the edge following ack is treated as a new request.
  - Dropping req before ack is illegal.
- x_do holds its last value until the next ack to the same requester.
- Both reqs held continuously → grants strictly alternate CPU, DMA, CPU, …
- Write transaction: x_do returns the written byte (write-first RAM).
- Address has no wrap logic: ram_a = requester address, unmodified.

Test Plan:
- AW=4, CLEAR_ON_RESET=1, CLEAR_VALUE=8'hA5, release reset → busy high for exactly 17 edges; ram_wr=0 with ram_a 0..15 in order; then CPU reads of addr 0 and addr 15 each return 8'hA5 with cpu_ack three edges after req.
- CPU writes 8'h3C to addr 14'h1234, then reads it back → write ack shows cpu_do=8'h3C; read ack shows cpu_do=8'h3C; ram_wr low for exactly 1 cycle.
- cpu_req and dma_req raised on the same edge, both held for 4 transactions → grant order CPU, DMA, CPU, DMA; each ack 1 cycle wide; dma_do untouched during CPU acks.
- dma_req held high from reset release during the sweep (AW=4) → no ram access from DMA until busy=0; DMA served immediately after CLR_END.
- Reset pulsed low while ram_wr=0 in ACCESS, and again at sweep address 7 → outputs return to reset values immediately, no ack is issued, and the sweep restarts at address 0.
- CLEAR_ON_RESET=0 → busy=0 from reset; the first CPU read is served 3 edges after reset release.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between CPU and DMA requesters,
// with an optional post-reset clear sweep that fills the RAM with a constant.
module ram_arbiter #(
    parameter int              AW             = 14,
    parameter int              DW             = 8,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [DW-1:0]   CLEAR_VALUE    = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_di,
    output logic [DW-1:0] cpu_do,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_wr,
    input  logic [AW-1:0] dma_a,
    input  logic [DW-1:0] dma_di,
    output logic [DW-1:0] dma_do,
    output logic          dma_ack,
    output logic          ram_wr,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_di,
    input  logic [DW-1:0] ram_do,
    output logic          busy,
    output logic [2:0]    dbg_state
);

    // Handshake: x_req is a level held (with x_a/x_wr/x_di stable) until a
    // one-cycle x_ack; x_do is valid during that ack and held until the next one.
    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_CLR_END = 3'd1,
        S_IDLE    = 3'd2,
        S_ACCESS  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          prio_q, prio_d;      // 0 = CPU preferred, 1 = DMA preferred
    logic          win_q, win_d;        // 0 = CPU, 1 = DMA
    logic          ram_wr_q, ram_wr_d;
    logic [AW-1:0] ram_a_q, ram_a_d;
    logic [DW-1:0] ram_di_q, ram_di_d;
    logic [DW-1:0] cpu_do_q, cpu_do_d;
    logic [DW-1:0] dma_do_q, dma_do_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic          busy_q, busy_d;
    logic          pick_dma;

    always_comb begin
        pick_dma  = dma_req && (!cpu_req || prio_q);
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;
        win_d     = win_q;
        ram_wr_d  = ram_wr_q;
        ram_a_d   = ram_a_q;
        ram_di_d  = ram_di_q;
        cpu_do_d  = cpu_do_q;
        dma_do_d  = dma_do_q;
        cpu_ack_d = 1'b0;
        dma_ack_d = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            S_CLEAR: begin
                ram_a_d  = cnt_q;
                ram_di_d = CLEAR_VALUE;
                ram_wr_d = 1'b0;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}}) state_d = S_CLR_END;
            end
            S_CLR_END: begin
                ram_wr_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            S_IDLE: begin
                ram_wr_d = 1'b1;
                if (cpu_req || dma_req) begin
                    win_d    = pick_dma;
                    ram_a_d  = pick_dma ? dma_a  : cpu_a;
                    ram_di_d = pick_dma ? dma_di : cpu_di;
                    ram_wr_d = pick_dma ? dma_wr : cpu_wr;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // RAM acts on this edge; releasing the strobe keeps writes one cycle long.
                ram_wr_d = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (win_q) begin
                    dma_do_d  = ram_do;
                    dma_ack_d = 1'b1;
                end else begin
                    cpu_do_d  = ram_do;
                    cpu_ack_d = 1'b1;
                end
                prio_d  = ~win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            cnt_q     <= '0;
            prio_q    <= 1'b0;
            win_q     <= 1'b0;
            ram_wr_q  <= 1'b1;
            ram_a_q   <= '0;
            ram_di_q  <= '0;
            cpu_do_q  <= '0;
            dma_do_q  <= '0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            busy_q    <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
            win_q     <= win_d;
            ram_wr_q  <= ram_wr_d;
            ram_a_q   <= ram_a_d;
            ram_di_q  <= ram_di_d;
            cpu_do_q  <= cpu_do_d;
            dma_do_q  <= dma_do_d;
            cpu_ack_q <= cpu_ack_d;
            dma_ack_q <= dma_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign cpu_do    = cpu_do_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_do    = dma_do_q;
    assign dma_ack   = dma_ack_q;
    assign ram_wr    = ram_wr_q;
    assign ram_a     = ram_a_q;
    assign ram_di    = ram_di_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
